// File: rtl/result_ascii_formatter_pkg.sv
// Shared definitions for the result ASCII formatter.
//   state_t      : top-level FSM state encoding
//   ASCII_ZERO   : code of the character '0'
//   DEF_WIDTH    : default binary input width
//   DEF_DIGITS   : default BCD digit count
//   cnt_width()  : width of a counter that must hold the value w
package result_ascii_formatter_pkg;

  localparam int         DEF_WIDTH  = 16;
  localparam int         DEF_DIGITS = 5;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/result_ascii_formatter_dabble_step.sv
// One double-dabble iteration (purely combinational).
//   i_bcd : DIGITS packed BCD digits before the step
//   i_bin : remaining binary bits before the step
//   o_bcd : digits after add-3 correction and the 1-bit left shift
//   o_bin : binary bits after the shift
module dabble_step
  import result_ascii_formatter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic [4*DIGITS-1:0] i_bcd,
  input  logic [WIDTH-1:0]    i_bin,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic [WIDTH-1:0]    o_bin
);

  localparam int BCD_W = 4 * DIGITS;

  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+WIDTH-1:0] w_cat;

  // Digits are at most 9 entering the step, so +3 never exceeds 4 bits.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = i_bcd[4*i +: 4];
    end
  end

  assign w_cat = {w_adj, i_bin} << 1;
  assign o_bcd = w_cat[BCD_W+WIDTH-1:WIDTH];
  assign o_bin = w_cat[WIDTH-1:0];

endmodule

// File: rtl/result_ascii_formatter.sv
// Binary-to-decimal ASCII formatter with leading-zero suppression.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : conversion request, honoured only in IDLE
//   value      : binary result, captured when start is accepted
//   busy       : high whenever the FSM is not in IDLE
//   char_valid : char_data/char_last hold a character
//   char_data  : ASCII digit, '0' + BCD digit
//   char_last  : final character of the value
//   char_ready : consumer accepts the character
//   done       : one-cycle pulse after the last character transfers
//
// state   | meaning
// IDLE    | waiting for start
// CONVERT | one double-dabble step per cycle, WIDTH cycles
// SEND    | streaming digits from the first non-zero one down to digit 0
// DONE    | done pulse, then back to IDLE
module result_ascii_formatter
  import result_ascii_formatter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             char_valid,
  output logic [7:0]       char_data,
  output logic             char_last,
  input  logic             char_ready,
  output logic             done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;

  logic [BCD_W-1:0]   w_bcd_step;
  logic [WIDTH-1:0]   w_bin_step;
  logic [PTR_W-1:0]   w_lead_ptr;
  logic [3:0]         w_digit;
  logic               w_last_step;

  dabble_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dabble_step (
    .i_bcd (r_bcd),
    .i_bin (r_shift),
    .o_bcd (w_bcd_step),
    .o_bin (w_bin_step)
  );

  assign w_last_step = (r_cnt == CNT_W'(1));

  // Highest non-zero digit of the final step's result; defaults to digit 0
  // so an all-zero value still emits a single '0'.
  always_comb begin
    w_lead_ptr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_bcd_step[4*i +: 4] != 4'd0)
        w_lead_ptr = PTR_W'(i);
    end
  end

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_ptr == PTR_W'(i))
        w_digit = r_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // Outputs decode registered state only, so char_valid never depends
  // on char_ready and data/last stay put during a stall.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    char_valid   = 1'b0;
    char_data    = 8'h00;
    char_last    = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start)
          w_state_next = CONVERT;
      end
      CONVERT: begin
        if (w_last_step)
          w_state_next = SEND;
      end
      SEND: begin
        char_valid = 1'b1;
        char_data  = ASCII_ZERO + {4'h0, w_digit};
        char_last  = (r_ptr == '0);
        if (char_ready && (r_ptr == '0))
          w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= value;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(WIDTH);
          end
        end
        CONVERT: begin
          r_shift <= w_bin_step;
          r_bcd   <= w_bcd_step;
          r_cnt   <= r_cnt - 1'b1;
          if (w_last_step)
            r_ptr <= w_lead_ptr;
        end
        SEND: begin
          if (char_ready && (r_ptr != '0))
            r_ptr <= r_ptr - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_ascii_formatter.sv
module tb_result_ascii_formatter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_last;
  logic        char_ready;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0] exp_q[$];

  result_ascii_formatter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .value      (value),
    .busy       (busy),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_last  (char_last),
    .char_ready (char_ready),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++)
      exp_q.push_back({(i == s.len() - 1), s[i]});
  endtask

  // Monitor / scoreboard: compares every transfer against the queue,
  // checks done follows the last transfer, and checks stall stability.
  logic [7:0] p_data;
  logic       p_last;
  logic       p_stall = 1'b0;
  logic       p_xlast = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      p_stall = 1'b0;
      p_xlast = 1'b0;
    end else begin
      if (p_xlast)
        chk("done_after_last", done, 1);
      else if (done)
        chk("done_spurious", done, 0);
      if (p_stall) begin
        chk("stall_valid_held", char_valid, 1);
        chk("stall_data_stable", char_data, p_data);
        chk("stall_last_stable", char_last, p_last);
      end
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_char", char_data, 0);
        end else begin
          e = exp_q.pop_front();
          chk("char_data", char_data, e[7:0]);
          chk("char_last", char_last, e[8]);
        end
      end
      p_stall = char_valid && !char_ready;
      p_data  = char_data;
      p_last  = char_last;
      p_xlast = char_valid && char_ready && char_last;
    end
  end

  task automatic do_start(input logic [15:0] v);
    @(posedge clk); #1;
    value = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the 1-based cycle count from the start cycle to first char_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!char_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!char_valid) timeout("wait_valid");
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) timeout("wait_done");
    @(posedge clk); #1;
    chk("idle_busy_low", busy, 0);
    chk("idle_done_low", done, 0);
  endtask

  task automatic run_expect(input logic [15:0] v, input string s);
    int lat;
    push_str(s);
    do_start(v);
    wait_valid(lat);
    wait_done();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_char_valid"}, char_valid, 0);
    chk({tag, "_char_data"},  char_data, 8'h00);
    chk({tag, "_char_last"},  char_last, 0);
    chk({tag, "_done"},       done, 0);
  endtask

  initial begin
    int lat;
    int n;
    rst        = 1'b0;
    start      = 1'b0;
    value      = '0;
    char_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Zero emits a single '0'
    run_expect(16'd0, "0");

    // Full-scale value: latency and back-to-back throughput
    push_str("65535");
    do_start(16'd65535);
    wait_valid(lat);
    chk("latency_65535", lat, 17);
    for (int i = 0; i < 5; i++) begin
      chk("stream_valid", char_valid, 1);
      @(posedge clk); #1;
    end
    chk("stream_end_valid", char_valid, 0);
    chk("stream_end_done", done, 1);
    wait_done();

    // Interior zero is kept
    run_expect(16'd1024, "1024");

    // Backpressure for three cycles
    char_ready = 1'b0;
    push_str("7");
    do_start(16'd7);
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      chk("stall_data_7", char_data, 8'h37);
      chk("stall_last_7", char_last, 1);
      @(posedge clk); #1;
    end
    char_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_xfer_done", done, 1);
    chk("stall_xfer_valid", char_valid, 0);
    wait_done();

    // Second start during CONVERT is ignored
    push_str("12345");
    do_start(16'd12345);
    repeat (4) begin
      @(posedge clk); #1;
      chk("busy_convert", busy, 1);
    end
    value = 16'd999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      chk("busy_continuous", busy, 1);
      @(posedge clk); #1;
      n++;
    end
    wait_done();

    // Reset in the middle of SEND, then recovery
    push_str("65535");
    do_start(16'd65535);
    wait_valid(lat);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("third_char_before_reset", char_data, 8'h35);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    run_expect(16'd42, "42");

    chk("queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/result_ascii_formatter.md
# result_ascii_formatter

Sequential binary-to-decimal formatter that sits directly downstream of the exponent datapath's 16-bit output register and upstream of the LCD controller. On a start pulse it captures the 16-bit result and converts it to five BCD digits with a one-shift-per-cycle double-dabble engine. It then streams the decimal value, leading zeros suppressed, as ASCII characters over a valid/ready handshake to the LCD character writer.

## Interface
Parameters:
- WIDTH, 16, binary input width.
- DIGITS, 5, BCD digit count; must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- value  in  WIDTH  binary result, sampled on the accepted start edge.
- busy  out  1  high in every state except IDLE.
- char_valid  out  1  char_data holds a valid character.
- char_data  out  8  ASCII character, 8'h30 + digit.
- char_last  out  1  high with the final character of the value.
- char_ready  in  1  consumer accepts the character when char_valid is also high.
- done  out  1  one-cycle pulse after the final character transfers.

## Operation
- States: IDLE → CONVERT → SEND → DONE → IDLE.
- IDLE:
  - start=1 loads value into the shift register, clears the BCD register, sets bit counter = WIDTH, and moves to CONVERT.
  - start in any other state is ignored; no queuing.
- CONVERT, one step per cycle:
  - Every BCD digit ≥ 5 gets +3.
  - The concatenation {bcd, shift} shifts left by 1.
  - Counter decrements.
  - After WIDTH steps the state moves to SEND.
- SEND:
  - Digit pointer starts at the most-significant non-zero digit.
  - If every digit is zero, the pointer starts at digit 0, so value 0 emits a single "0".
  - char_data = 8'h30 + bcd[pointer].
  - char_last = (pointer == 0).
  - On char_valid && char_ready, the pointer decrements. The transfer that has char_last=1 moves the state to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - Once char_valid rises, it stays high until the transfer.
  - char_data and char_last remain stable while char_valid=1 and char_ready=0.
  - char_valid never depends combinationally on char_ready.
- Width rules:
  - Each BCD digit is 4 bits. The add-3 result fits in 4 bits because inputs are ≤ 9 before adjustment.
  - No overflow is possible for WIDTH=16 (maximum 65535).
- value changes after capture have no effect on the conversion in progress.

## Timing
- Reset values: busy=0, char_valid=0, char_data=8'h00, char_last=0, done=0. Internal registers are zero and the state is IDLE.
- Reset asserted mid-operation (any state) aborts immediately to the reset values. No partial character is completed.
- Conversion timing:
  - Start accepted at edge E0. CONVERT occupies edges E1..E16.
  - busy is high from after E0.
  - char_valid rises after E16, giving a latency of 17 cycles from start to the first char_valid.
- Throughput: with char_ready held at 1, one character transfers per cycle.
- done: high in the cycle after the last transfer edge. busy falls together with done falling (back in IDLE).
- Earliest next start: in the cycle after done, i.e. once busy=0.
- Best-case total for 65535 at constant ready: 17 + 5 + 1 = 23 cycles from start to return to IDLE.

## Structure
- Shared package:
  - State enum {IDLE, CONVERT, SEND, DONE}.
  - ASCII_ZERO = 8'h30.
  - Default WIDTH/DIGITS.
  - Bit-counter width, $clog2(WIDTH+1).
- Sub-module dabble_step (combinational): per-digit add-3 over DIGITS digits plus a 1-bit left shift of {bcd, bin}. It is instantiated once by the FSM.
- The leading-zero scan is a priority encoder computed when entering SEND. It is registered into the pointer and not recomputed per character.

## Test plan
- value=0, ready=1 → exactly one character 8'h30 with char_last=1. done pulses in the cycle after the transfer.
- value=65535, ready=1 → 8'h36, 8'h35, 8'h35, 8'h33, 8'h35 on consecutive cycles, last on 8'h35. First char_valid appears 17 cycles after start.
- value=1024 → 8'h31, 8'h30, 8'h32, 8'h34. The interior zero is emitted, not suppressed.
- value=7 with ready low for 3 cycles after char_valid → char_data=8'h37 and char_last=1 held stable all 3 cycles. The transfer occurs on the first ready-high edge.
- A second start, with a different value, during CONVERT → ignored. Output still reflects the first value, and busy stays continuous.
- rst low during SEND of 65535 (after 2 characters) → all outputs return to reset values immediately. The next start with value=42 emits 8'h34, 8'h32 correctly.
